// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3x3 window multiply-accumulate with double-buffered kernel weights and bias,
// arithmetic-shift requantization with saturation, and raster position / framing flags.
// Optional build macro: CONV3X3_RELU_EN clamps negative saturated results to zero.
// Pipeline: S1 products -> S2 row sums -> S3 accumulate + bias -> output requantize/count.
module conv3x3_window_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned ACCW  = 36
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_clr_i,
  input  logic                 valid_in_i,
  input  logic signed [DW-1:0] tap0_i,
  input  logic signed [DW-1:0] tap1_i,
  input  logic signed [DW-1:0] tap2_i,
  input  logic signed [DW-1:0] tap3_i,
  input  logic signed [DW-1:0] tap4_i,
  input  logic signed [DW-1:0] tap5_i,
  input  logic signed [DW-1:0] tap6_i,
  input  logic signed [DW-1:0] tap7_i,
  input  logic signed [DW-1:0] tap8_i,
  input  logic [7:0]           out_width_i,
  input  logic [7:0]           out_height_i,
  input  logic                 w_wr_i,
  input  logic [3:0]           w_addr_i,
  input  logic signed [DW-1:0] w_data_i,
  input  logic                 w_commit_i,
  output logic signed [DW-1:0] pix_out_o,
  output logic                 valid_out_o,
  output logic                 eol_o,
  output logic                 frame_done_o,
  output logic [7:0]           out_col_o,
  output logic [7:0]           out_row_o
);

  localparam int unsigned NumTaps = 9;
  localparam int unsigned NumW    = NumTaps + 1;  // nine coefficients plus bias
  localparam int unsigned BiasIdx = 9;
  localparam int unsigned PW      = 2 * DW;

  localparam logic signed [ACCW-1:0] YMax = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMin = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]   PixMax = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   PixMin = {1'b1, {(DW-1){1'b0}}};

  // ---------------------------------------------------------------------------------------------
  // Weight banks
  // ---------------------------------------------------------------------------------------------
  logic signed [DW-1:0] shadow_q [NumW];
  logic signed [DW-1:0] active_q [NumW];

  // Shadow takes writes; commit copies the pre-write shadow so a same-cycle write stays shadow-only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumW; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (w_commit_i) begin
        for (int i = 0; i < NumW; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (w_wr_i && (w_addr_i < 4'(NumW))) begin
        shadow_q[w_addr_i] <= w_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S1: per-tap products
  // ---------------------------------------------------------------------------------------------
  logic signed [DW-1:0] taps [NumTaps];
  logic signed [PW-1:0] prod_d [NumTaps];
  logic signed [PW-1:0] prod_q [NumTaps];
  logic signed [DW-1:0] bias1_q;
  logic                 s1_valid_q;
  logic                 accept;

  // sync_clr wins over valid_in: windows presented alongside a clear are dropped
  assign accept = valid_in_i & ~sync_clr_i;

  // Gather the window ports into an indexable array (row-major, tap0 top-left)
  always_comb begin
    taps[0] = tap0_i;
    taps[1] = tap1_i;
    taps[2] = tap2_i;
    taps[3] = tap3_i;
    taps[4] = tap4_i;
    taps[5] = tap5_i;
    taps[6] = tap6_i;
    taps[7] = tap7_i;
    taps[8] = tap8_i;
  end

  // Full-precision signed products against the active bank
  always_comb begin
    for (int i = 0; i < NumTaps; i++) begin
      prod_d[i] = PW'(taps[i]) * PW'(active_q[i]);
    end
  end

  // S1 register; bias is captured with the products so a later commit cannot skew this window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      bias1_q    <= '0;
      for (int i = 0; i < NumTaps; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        bias1_q <= active_q[BiasIdx];
        for (int i = 0; i < NumTaps; i++) begin
          prod_q[i] <= prod_d[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S2: row sums
  // ---------------------------------------------------------------------------------------------
  logic signed [ACCW-1:0] row_d [3];
  logic signed [ACCW-1:0] row_q [3];
  logic signed [DW-1:0]   bias2_q;
  logic                   s2_valid_q;

  // Sign-extend each product to the accumulator width before summing a kernel row
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_d[r] = ACCW'(prod_q[3*r]) + ACCW'(prod_q[3*r+1]) + ACCW'(prod_q[3*r+2]);
    end
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      bias2_q    <= '0;
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= '0;
      end
    end else begin
      s2_valid_q <= s1_valid_q & ~sync_clr_i;
      if (s1_valid_q) begin
        bias2_q <= bias1_q;
        for (int r = 0; r < 3; r++) begin
          row_q[r] <= row_d[r];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S3: accumulate with bias pre-scaled into the accumulator's fixed-point position
  // ---------------------------------------------------------------------------------------------
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_q;
  logic                   s3_valid_q;

  // Final sum of the three rows plus the scaled bias
  always_comb begin
    acc_d = row_q[0] + row_q[1] + row_q[2] + (ACCW'(bias2_q) <<< SHIFT);
  end

  // S3 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      s3_valid_q <= s2_valid_q & ~sync_clr_i;
      if (s2_valid_q) begin
        acc_q <= acc_d;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output: requantize, saturate, raster position
  // ---------------------------------------------------------------------------------------------
  logic signed [ACCW-1:0] y;
  logic signed [DW-1:0]   sat_y;

  // Floor shift, clamp to the signed output range, optional ReLU
  always_comb begin
    y = acc_q >>> SHIFT;
    if (y > YMax) begin
      sat_y = PixMax;
    end else if (y < YMin) begin
      sat_y = PixMin;
    end else begin
      sat_y = y[DW-1:0];
    end
`ifdef CONV3X3_RELU_EN
    if (sat_y[DW-1]) begin
      sat_y = '0;
    end
`endif
  end

  logic signed [DW-1:0] pix_d, pix_q;
  logic                 valid_out_d, valid_out_q;
  logic                 eol_d, eol_q;
  logic                 frame_done_d, frame_done_q;
  logic [7:0]           out_col_d, out_col_q;
  logic [7:0]           out_row_d, out_row_q;
  logic [7:0]           col_d, col_q;
  logic [7:0]           row_d2, row_cnt_q;

  // Output next state: report current position, advance raster counters, flag line/frame end
  always_comb begin
    pix_d        = pix_q;
    valid_out_d  = s3_valid_q;
    eol_d        = 1'b0;
    frame_done_d = 1'b0;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    col_d        = col_q;
    row_d2       = row_cnt_q;
    if (s3_valid_q) begin
      pix_d     = sat_y;
      out_col_d = col_q;
      out_row_d = row_cnt_q;
      // >= so a live shrink of the geometry wraps at once instead of running on to 255
      if (col_q >= out_width_i - 8'd1) begin
        eol_d = 1'b1;
        col_d = '0;
        if (row_cnt_q >= out_height_i - 8'd1) begin
          frame_done_d = 1'b1;
          row_d2       = '0;
        end else begin
          row_d2 = row_cnt_q + 8'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
    end
    if (sync_clr_i) begin
      valid_out_d  = 1'b0;
      eol_d        = 1'b0;
      frame_done_d = 1'b0;
      col_d        = '0;
      row_d2       = '0;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q        <= '0;
      valid_out_q  <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      col_q        <= '0;
      row_cnt_q    <= '0;
    end else begin
      pix_q        <= pix_d;
      valid_out_q  <= valid_out_d;
      eol_q        <= eol_d;
      frame_done_q <= frame_done_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      col_q        <= col_d;
      row_cnt_q    <= row_d2;
    end
  end

  assign pix_out_o    = pix_q;
  assign valid_out_o  = valid_out_q;
  assign eol_o        = eol_q;
  assign frame_done_o = frame_done_q;
  assign out_col_o    = out_col_q;
  assign out_row_o    = out_row_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Bench for conv3x3_window_mac: directed vector table, multi-cycle corner sequences and a
// randomized stream scored against a queue-based arithmetic reference model.
module tb_conv3x3_window_mac;

  localparam int SH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sync_clr = 1'b0;
  logic               valid_in = 1'b0;
  logic signed [15:0] tap [9];
  logic [7:0]         out_width = 8'd4;
  logic [7:0]         out_height = 8'd3;
  logic               w_wr = 1'b0;
  logic [3:0]         w_addr = 4'd0;
  logic signed [15:0] w_data = 16'sd0;
  logic               w_commit = 1'b0;
  logic [15:0]        pix_out;
  logic               valid_out, eol, frame_done;
  logic [7:0]         out_col, out_row;

  conv3x3_window_mac #(.DW(16), .SHIFT(SH), .ACCW(36)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr_i   (sync_clr),
    .valid_in_i   (valid_in),
    .tap0_i       (tap[0]),
    .tap1_i       (tap[1]),
    .tap2_i       (tap[2]),
    .tap3_i       (tap[3]),
    .tap4_i       (tap[4]),
    .tap5_i       (tap[5]),
    .tap6_i       (tap[6]),
    .tap7_i       (tap[7]),
    .tap8_i       (tap[8]),
    .out_width_i  (out_width),
    .out_height_i (out_height),
    .w_wr_i       (w_wr),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .w_commit_i   (w_commit),
    .pix_out_o    (pix_out),
    .valid_out_o  (valid_out),
    .eol_o        (eol),
    .frame_done_o (frame_done),
    .out_col_o    (out_col),
    .out_row_o    (out_row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  typedef struct { int due; logic [15:0] pix; } exp_t;
  exp_t    q[$];
  shortint m_shadow [10];
  shortint m_active [10];
  int      cyc = 0;
  int      mcol = 0;
  int      mrow = 0;

  logic [15:0] pix_log[$];
  int          col_log[$];
  int          row_log[$];
  logic [1:0]  flag_log[$];

  typedef struct {
    string       name;
    shortint     kall, k4, bias, tall, t4;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Window result from plain integer arithmetic on the current taps and active bank
  function automatic logic [15:0] model_pix();
    longint acc = 0;
    longint y;
    for (int i = 0; i < 9; i++) acc += longint'(tap[i]) * longint'(m_active[i]);
    acc += longint'(m_active[9]) * (longint'(1) << SH);
    y = acc >>> SH;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`ifdef CONV3X3_RELU_EN
    if (y < 0) y = 0;
`endif
    return y[15:0];
  endfunction

  function automatic logic [15:0] relu_adj(input logic [15:0] v);
`ifdef CONV3X3_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic check_out();
    exp_t e;
    logic ex_eol, ex_fd;
    if (q.size() > 0 && q[0].due == cyc) begin
      e      = q.pop_front();
      ex_eol = (mcol == int'(out_width) - 1);
      ex_fd  = ex_eol && (mrow == int'(out_height) - 1);
      chk("valid_out", valid_out, 1);
      chk("pix_out", pix_out, e.pix);
      chk("out_col", out_col, mcol);
      chk("out_row", out_row, mrow);
      chk("eol", eol, ex_eol);
      chk("frame_done", frame_done, ex_fd);
      pix_log.push_back(pix_out);
      col_log.push_back(int'(out_col));
      row_log.push_back(int'(out_row));
      flag_log.push_back({eol, frame_done});
      if (ex_eol) begin
        mcol = 0;
        if (ex_fd) mrow = 0;
        else mrow++;
      end else begin
        mcol++;
      end
    end else begin
      chk("valid_out idle", valid_out, 0);
      chk("eol idle", eol, 0);
      chk("frame_done idle", frame_done, 0);
    end
  endtask

  // One clock: update the model with what the DUT samples at this edge, then check after it
  task automatic tick();
    exp_t e;
    if (sync_clr) begin
      q.delete();
      mcol = 0;
      mrow = 0;
    end else if (valid_in) begin
      e.due = cyc + 3;
      e.pix = model_pix();
      q.push_back(e);
    end
    if (w_commit) m_active = m_shadow;
    if (w_wr && w_addr < 4'd10) m_shadow[w_addr] = w_data;
    @(posedge clk);
    #1;
    check_out();
    cyc++;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; sync_clr = 1'b0; w_wr = 1'b0; w_commit = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input shortint d);
    valid_in = 1'b0; w_wr = 1'b1; w_addr = a[3:0]; w_data = d;
    tick();
    w_wr = 1'b0;
  endtask

  task automatic commit();
    valid_in = 1'b0; w_commit = 1'b1;
    tick();
    w_commit = 1'b0;
  endtask

  task automatic set_taps(input shortint tall, input shortint t4);
    for (int i = 0; i < 9; i++) tap[i] = tall;
    tap[4] = t4;
  endtask

  task automatic window(input shortint tall, input shortint t4);
    set_taps(tall, t4);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic load(input shortint kall, input shortint k4, input shortint bias);
    for (int i = 0; i < 9; i++) wr(i, (i == 4) ? k4 : kall);
    wr(9, bias);
    commit();
  endtask

  task automatic clear_logs();
    pix_log.delete(); col_log.delete(); row_log.delete(); flag_log.delete();
  endtask

  task automatic set_vec(input int idx, input string nm, input shortint kall, input shortint k4,
                         input shortint bias, input shortint tall, input shortint t4,
                         input logic [15:0] ex);
    vecs[idx].name = nm; vecs[idx].kall = kall; vecs[idx].k4 = k4; vecs[idx].bias = bias;
    vecs[idx].tall = tall; vecs[idx].t4 = t4; vecs[idx].exp = ex;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 9; i++) tap[i] = 16'sd0;
    for (int i = 0; i < 10; i++) begin m_shadow[i] = 0; m_active[i] = 0; end

    set_vec(0, "identity",    0,      256,    0,   0,      1234,   16'd1234);
    set_vec(1, "sat_pos",     32767,  32767,  0,   32767,  32767,  16'h7FFF);
    set_vec(2, "sat_negneg",  -32768, -32768, 0,   -32768, -32768, 16'h7FFF);
    set_vec(3, "sat_neg",     32767,  32767,  0,   -32768, -32768, 16'h8000);
    set_vec(4, "floor_m1",    0,      1,      0,   0,      -1,     16'hFFFF);
    set_vec(5, "floor_255",   0,      1,      0,   0,      255,    16'h0000);
    set_vec(6, "floor_m257",  0,      1,      0,   0,      -257,   16'hFFFE);
    set_vec(7, "bias_pos",    0,      0,      100, 1234,   1234,   16'd100);
    set_vec(8, "bias_neg",    0,      256,    -5,  0,      3,      16'hFFFE);
    set_vec(9, "sum9",        1,      1,      0,   256,    256,    16'd9);

    // Reset state
    #1;
    chk("reset pix_out", pix_out, 0);
    chk("reset valid_out", valid_out, 0);
    chk("reset eol", eol, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset out_col", out_col, 0);
    chk("reset out_row", out_row, 0);
    #20;
    rst_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      load(vecs[v].kall, vecs[v].k4, vecs[v].bias);
      clear_logs();
      window(vecs[v].tall, vecs[v].t4);
      idle(4);
      chk({"vec ", vecs[v].name, " count"}, pix_log.size(), 1);
      if (pix_log.size() > 0) chk({"vec ", vecs[v].name, " pix"}, pix_log[0], relu_adj(vecs[v].exp));
    end

    // Framing: 4x3 frame, 13 back-to-back windows
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    load(0, 256, 0);
    clear_logs();
    for (int i = 0; i < 13; i++) begin
      set_taps(0, shortint'(i));
      valid_in = 1'b1;
      tick();
    end
    idle(4);
    chk("frame count", flag_log.size(), 13);
    if (flag_log.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        chk($sformatf("frame eol px%0d", i), flag_log[i][1], (i % 4 == 3) && (i < 12));
        chk($sformatf("frame done px%0d", i), flag_log[i][0], i == 11);
      end
      chk("frame px12 col", col_log[12], 0);
      chk("frame px12 row", row_log[12], 0);
    end

    // Commit mid-stream: commit presented with window 2 takes effect from window 3
    load(0, 256, 0);
    wr(4, 512);
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      set_taps(0, 100);
      valid_in = 1'b1;
      w_commit = (i == 2);
      tick();
    end
    idle(4);
    chk("commit count", pix_log.size(), 6);
    if (pix_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("commit px%0d", i), pix_log[i], (i < 3) ? 100 : 200);
    end

    // Write and commit in the same cycle: the written value stays in the shadow bank
    clear_logs();
    w_wr = 1'b1; w_addr = 4'd4; w_data = 16'sd768; w_commit = 1'b1; valid_in = 1'b0;
    tick();
    w_wr = 1'b0; w_commit = 1'b0;
    window(0, 100);
    idle(4);
    commit();
    window(0, 100);
    idle(4);
    chk("wr+commit count", pix_log.size(), 2);
    if (pix_log.size() == 2) begin
      chk("wr+commit old active", pix_log[0], 200);
      chk("wr+commit after commit", pix_log[1], 300);
    end

    // sync_clr with two windows in flight, plus a window presented alongside the clear
    clear_logs();
    window(0, 50);
    window(0, 60);
    set_taps(0, 70); valid_in = 1'b1; sync_clr = 1'b1;
    tick();
    valid_in = 1'b0; sync_clr = 1'b0;
    idle(5);
    chk("clear dropped", pix_log.size(), 0);
    window(0, 50);
    idle(4);
    chk("clear next count", pix_log.size(), 1);
    if (pix_log.size() == 1) begin
      chk("clear next col", col_log[0], 0);
      chk("clear next row", row_log[0], 0);
      chk("clear next pix", pix_log[0], 150);
    end

    // Asynchronous reset mid-frame with windows in flight
    for (int i = 0; i < 6; i++) begin
      set_taps(0, 1234);
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst pix_out", pix_out, 0);
    chk("async rst valid_out", valid_out, 0);
    chk("async rst eol", eol, 0);
    chk("async rst frame_done", frame_done, 0);
    chk("async rst out_col", out_col, 0);
    chk("async rst out_row", out_row, 0);
    q.delete(); mcol = 0; mrow = 0;
    for (int i = 0; i < 10; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    window(0, 1234);
    idle(4);
    chk("post rst count", pix_log.size(), 1);
    if (pix_log.size() == 1) begin
      chk("post rst pix (weights 0)", pix_log[0], 0);
      chk("post rst col", col_log[0], 0);
      chk("post rst row", row_log[0], 0);
    end

    // Randomized stream with live weight writes, commits and occasional clears
    out_width = 8'd5;
    out_height = 8'd3;
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    load(0, 256, 0);
    for (int n = 0; n < 400; n++) begin
      valid_in = ($urandom % 4) != 0;
      for (int i = 0; i < 9; i++) begin
        if ($urandom % 2 == 1) tap[i] = 16'($urandom);
        else tap[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
      end
      w_wr     = ($urandom % 12) == 0;
      w_addr   = 4'($urandom);
      w_data   = 16'(int'($urandom_range(0, 1023)) - 512);
      w_commit = ($urandom % 20) == 0;
      sync_clr = ($urandom % 80) == 0;
      tick();
    end
    idle(6);
    chk("drain empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
